// File: rtl/dbg_responder_if.sv
// Monitor debug port bundle between the CDECV core, the monitor and dbg_responder.
// The slave side is the responder; the master side drives the core state and dbg_addr.
interface dbg_responder_if;
  logic       cpu_clock;
  logic       cpu_reset;
  logic [7:0] cpu_pc;
  logic [7:0] cpu_ir;
  logic [7:0] cpu_a;
  logic [7:0] cpu_b;
  logic [7:0] cpu_ma;
  logic [7:0] cpu_md;
  logic [3:0] cpu_flags;
  logic [3:0] dbg_addr;
  logic [15:0] dbg_data;
  logic       dbg_we;
  logic       dbg_clock;
  logic       dbg_end_sq;

  // Handshake: there is no ready/backpressure. dbg_we is a pure strobe marking a
  // fresh snapshot. Once it rises, every word selected by dbg_addr is stable
  // until the next CAPTURE cycle. dbg_data follows dbg_addr one clk later.
  modport slave (
    input  cpu_clock, cpu_reset, cpu_pc, cpu_ir, cpu_a, cpu_b, cpu_ma, cpu_md,
           cpu_flags, dbg_addr,
    output dbg_data, dbg_we, dbg_clock, dbg_end_sq
  );

  modport master (
    output cpu_clock, cpu_reset, cpu_pc, cpu_ir, cpu_a, cpu_b, cpu_ma, cpu_md,
           cpu_flags, dbg_addr,
    input  dbg_data, dbg_we, dbg_clock, dbg_end_sq
  );
endinterface

// File: rtl/dbg_responder.sv
// CDECV debug responder: snapshots core state on each synchronised cpu_clock rise.
// Optional jump-to-self halt detection is enabled with `define DBG_END_SQ_EN.
module dbg_responder #(
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dbg_responder_if.slave  bus,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, NOTIFY = 2'd2} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sclk, sclk_d, rise;
  logic                   pending, pending_next;
  logic [7:0]             hold_cnt, hold_next;
  logic                   capture;
  logic [15:0]            step_cnt;
  logic [7:0]             prev_pc;
  logic [15:0]            snap_w0, snap_w1, snap_w2, snap_step;
  logic [3:0]             snap_flags;
  logic [7:0]             snap_prev;
  logic [15:0]            rd_word, data_q;

  assign sclk = sync_q[SYNC_STAGES-1];

  // A rise seen while the core is held in reset is discarded.
  assign rise = sclk & ~sclk_d & ~bus.cpu_reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      sclk_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.cpu_clock};
      sclk_d <= sclk;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    hold_next    = hold_cnt;
    capture      = 1'b0;
    if (bus.cpu_reset) begin
      state_next   = IDLE;
      pending_next = 1'b0;
      hold_next    = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) state_next = CAPTURE;
        end
        CAPTURE: begin
          capture    = 1'b1;
          hold_next  = 8'd0;
          state_next = NOTIFY;
          if (rise) pending_next = 1'b1;
        end
        NOTIFY: begin
          if (hold_cnt == HOLD_LAST) begin
            // A rise landing on the expiry cycle is treated as pending too,
            // otherwise it would be lost on the way back to IDLE.
            if (pending || rise) begin
              state_next   = CAPTURE;
              pending_next = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            hold_next = hold_cnt + 8'd1;
            if (rise) pending_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt   <= 16'h0000;
      prev_pc    <= 8'h00;
      snap_w0    <= 16'h0000;
      snap_w1    <= 16'h0000;
      snap_w2    <= 16'h0000;
      snap_flags <= 4'h0;
      snap_prev  <= 8'h00;
      snap_step  <= 16'h0000;
    end else if (bus.cpu_reset) begin
      step_cnt <= 16'h0000;
    end else if (capture) begin
      step_cnt   <= step_cnt + 16'd1;
      prev_pc    <= bus.cpu_pc;
      snap_w0    <= {bus.cpu_ir, bus.cpu_pc};
      snap_w1    <= {bus.cpu_b, bus.cpu_a};
      snap_w2    <= {bus.cpu_md, bus.cpu_ma};
      snap_flags <= bus.cpu_flags;
      snap_prev  <= prev_pc;
      snap_step  <= step_cnt + 16'd1;
    end
  end

`ifdef DBG_END_SQ_EN
  logic prev_valid;
  logic end_sq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_valid <= 1'b0;
      end_sq     <= 1'b0;
    end else if (bus.cpu_reset) begin
      prev_valid <= 1'b0;
      end_sq     <= 1'b0;
    end else if (capture) begin
      prev_valid <= 1'b1;
      if (prev_valid && (bus.cpu_pc == prev_pc)) end_sq <= 1'b1;
    end
  end

  assign bus.dbg_end_sq = end_sq;
`else
  assign bus.dbg_end_sq = 1'b0;
`endif

  always_comb begin
    rd_word = 16'h0000;
    case (bus.dbg_addr)
      4'd0:    rd_word = snap_w0;
      4'd1:    rd_word = snap_w1;
      4'd2:    rd_word = snap_w2;
      4'd3:    rd_word = {12'h000, snap_flags};
      4'd14:   rd_word = {8'h00, snap_prev};
      4'd15:   rd_word = snap_step;
      default: rd_word = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= 16'h0000;
    else       data_q <= rd_word;
  end

  assign bus.dbg_data  = data_q;
  assign bus.dbg_we    = (state == NOTIFY);
  assign bus.dbg_clock = sclk;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dbg_responder.sv
// Directed bench for dbg_responder: vector table of core states plus hand-written
// sequences for back-to-back rises, halt detection, cpu_reset, wrap and async reset.
module tb_dbg_responder;

  localparam int HOLD = 4;
  localparam int SYNC = 2;

  typedef struct {
    logic [7:0]  pc, ir, a, b, ma, md;
    logic [3:0]  flags;
    logic [15:0] w0, w1, w2, w3, w14, w15;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [1:0]  dbg_state;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  vec_t        vecs[4];

  dbg_responder_if bus();

  dbg_responder #(.HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic read_word(input logic [3:0] addr, output logic [15:0] data);
    bus.dbg_addr = addr;
    @(negedge clk);
    data = bus.dbg_data;
  endtask

  task automatic check_word(input logic [3:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    exp_q.push_back(exp);
    read_word(addr, d);
    check($sformatf("word%0d", addr), d, exp_q.pop_front());
  endtask

  function automatic vec_t mk(input logic [7:0] pc);
    vec_t v;
    v = '{pc: pc, ir: 8'h00, a: 8'h00, b: 8'h00, ma: 8'h00, md: 8'h00, flags: 4'h0,
          w0: 16'h0, w1: 16'h0, w2: 16'h0, w3: 16'h0, w14: 16'h0, w15: 16'h0};
    return v;
  endfunction

  // driver: present core state, raise cpu_clock, measure the dbg_we strobe
  task automatic do_step(input vec_t v, output int we_len);
    int t;
    bus.cpu_pc = v.pc; bus.cpu_ir = v.ir; bus.cpu_a = v.a; bus.cpu_b = v.b;
    bus.cpu_ma = v.ma; bus.cpu_md = v.md; bus.cpu_flags = v.flags;
    bus.cpu_clock = 1'b1;
    t = 0;
    we_len = 0;
    while (!bus.dbg_we && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.dbg_we) begin
      check_bit("step_timeout", 1'b0, 1'b1);
    end else begin
      check_bit("dbg_clock_high", bus.dbg_clock, 1'b1);
      while (bus.dbg_we && we_len < 300) begin
        we_len++;
        @(negedge clk);
      end
    end
    bus.cpu_clock = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  initial begin
    int          we_len;
    int          idx;
    int          run1, gap, run2;
    logic        we_hist[24];
    logic [15:0] exp_cnt;
    logic        exp_end;
    vec_t        v;

    vecs[0] = '{pc: 8'h12, ir: 8'hA5, a: 8'h01, b: 8'h02, ma: 8'h00, md: 8'h00, flags: 4'hC,
                w0: 16'hA512, w1: 16'h0201, w2: 16'h0000, w3: 16'h000C, w14: 16'h0000, w15: 16'h0001};
    vecs[1] = '{pc: 8'h34, ir: 8'h5A, a: 8'hFF, b: 8'h80, ma: 8'h3C, md: 8'hC3, flags: 4'h3,
                w0: 16'h5A34, w1: 16'h80FF, w2: 16'hC33C, w3: 16'h0003, w14: 16'h0012, w15: 16'h0002};
    vecs[2] = '{pc: 8'h00, ir: 8'hFF, a: 8'h00, b: 8'h00, ma: 8'hFF, md: 8'h01, flags: 4'hF,
                w0: 16'hFF00, w1: 16'h0000, w2: 16'h01FF, w3: 16'h000F, w14: 16'h0034, w15: 16'h0003};
    vecs[3] = '{pc: 8'hFE, ir: 8'h01, a: 8'h7E, b: 8'h81, ma: 8'h10, md: 8'h20, flags: 4'h0,
                w0: 16'h01FE, w1: 16'h817E, w2: 16'h2010, w3: 16'h0000, w14: 16'h0000, w15: 16'h0004};
`ifdef DBG_END_SQ_EN
    exp_end = 1'b1;
`else
    exp_end = 1'b0;
`endif

    // reset
    reset = 1'b1;
    bus.cpu_clock = 1'b0; bus.cpu_reset = 1'b0; bus.dbg_addr = 4'd0;
    bus.cpu_pc = 8'h00; bus.cpu_ir = 8'h00; bus.cpu_a = 8'h00; bus.cpu_b = 8'h00;
    bus.cpu_ma = 8'h00; bus.cpu_md = 8'h00; bus.cpu_flags = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_bit("reset_we", bus.dbg_we, 1'b0);
    check_bit("reset_end_sq", bus.dbg_end_sq, 1'b0);
    check_bit("reset_clock", bus.dbg_clock, 1'b0);
    check("reset_state", {14'h0, dbg_state}, 16'h0000);
    for (int a = 0; a < 16; a++) check_word(4'(a), 16'h0000);

    // table-driven single steps
    for (int i = 0; i < 4; i++) begin
      do_step(vecs[i], we_len);
      check("we_width", 16'(we_len), 16'(HOLD));
      check_word(4'd0, vecs[i].w0);
      check_word(4'd1, vecs[i].w1);
      check_word(4'd2, vecs[i].w2);
      check_word(4'd3, vecs[i].w3);
      check_word(4'd7, 16'h0000);
      check_word(4'd14, vecs[i].w14);
      check_word(4'd15, vecs[i].w15);
      check_bit("end_sq_distinct_pc", bus.dbg_end_sq, 1'b0);
    end
    exp_cnt = 16'd4;

    // jump-to-self halt: two steps at the same pc
    do_step(mk(8'h30), we_len);
    check_bit("end_sq_first_30", bus.dbg_end_sq, 1'b0);
    check_word(4'd14, 16'h00FE);
    do_step(mk(8'h30), we_len);
    exp_cnt = 16'd6;
    check_bit("end_sq_second_30", bus.dbg_end_sq, exp_end);
    check_word(4'd14, 16'h0030);
    check_word(4'd15, exp_cnt);

    // cpu_reset pulse: flag cleared, snapshot retained, counter restarts
    bus.cpu_reset = 1'b1;
    @(negedge clk);
    bus.cpu_reset = 1'b0;
    @(negedge clk);
    check_bit("end_sq_after_cpu_reset", bus.dbg_end_sq, 1'b0);
    check_word(4'd15, exp_cnt);
    do_step(mk(8'h44), we_len);
    exp_cnt = 16'd1;
    check_word(4'd15, exp_cnt);
    check_word(4'd0, 16'h0044);

    // back-to-back rises: second rise lands while the first strobe is pending
    bus.cpu_pc = 8'h55;
    bus.cpu_clock = 1'b1;
    @(negedge clk);
    bus.cpu_clock = 1'b0;
    @(negedge clk);
    bus.cpu_clock = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      we_hist[k] = bus.dbg_we;
    end
    bus.cpu_clock = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    idx = 0; run1 = 0; gap = 0; run2 = 0;
    while (idx < 24 && !we_hist[idx]) idx++;
    while (idx < 24 && we_hist[idx]) begin run1++; idx++; end
    while (idx < 24 && !we_hist[idx]) begin gap++; idx++; end
    while (idx < 24 && we_hist[idx]) begin run2++; idx++; end
    check("b2b_run1", 16'(run1), 16'(HOLD));
    check("b2b_gap", 16'(gap), 16'd1);
    check("b2b_run2", 16'(run2), 16'(HOLD));
    exp_cnt = 16'd3;
    check_word(4'd15, exp_cnt);

    // counter wrap from FFFF
    force dut.step_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.step_cnt;
    @(negedge clk);
    do_step(mk(8'h66), we_len);
    check_word(4'd15, 16'h0000);

    // asynchronous reset in the middle of a strobe
    bus.dbg_addr = 4'd0;
    bus.cpu_clock = 1'b1;
    idx = 0;
    while (!bus.dbg_we && idx < 20) begin
      @(negedge clk);
      idx++;
    end
    check_bit("notify_reached", bus.dbg_we, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_bit("async_reset_we", bus.dbg_we, 1'b0);
    check_bit("async_reset_clock", bus.dbg_clock, 1'b0);
    check("async_reset_data", bus.dbg_data, 16'h0000);
    bus.cpu_clock = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 16; a++) check_word(4'(a), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbg_responder.md
# dbg_responder

CDECV-side end of the monitor debug port. Samples the processor's architectural state on every CPU clock step, holds it in a 16-word snapshot that the monitor reads by `dbg_addr`, and signals the monitor with a new-snapshot strobe, a mirrored CPU clock and an end-of-sequence (halt) flag. Sits between the CDECV core and the monitor subsystem, in the monitor's `clk` domain.

## Interface
- `HOLD_CYCLES`, default 4: width of the `dbg_we` strobe in `clk` cycles, legal range 1..255.
- `SYNC_STAGES`, default 2: flip-flop stages synchronising `cpu_clock`, legal range 2..4.

- `clk`  in  1  system clock; the monitor clock, shared with `dbg_addr`.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cpu_clock`  in  1  CDECV step clock, i.e. the monitor's clock-to-CDECV output. Asynchronous to `clk`.
- `cpu_reset`  in  1  CDECV reset, i.e. the monitor's reset-to-CDECV output. Synchronous to `clk`, active-high.
- `cpu_pc`, `cpu_ir`, `cpu_a`, `cpu_b`, `cpu_ma`, `cpu_md`  in  8 each  core state.
- `cpu_flags`  in  4  core flags.
- `dbg_addr`  in  4  snapshot word select.
- `dbg_data`  out  16  selected snapshot word.
- `dbg_we`  out  1  new-snapshot strobe.
- `dbg_clock`  out  1  synchronised copy of `cpu_clock`.
- `dbg_end_sq`  out  1  sticky halt/end-of-sequence flag.

## Operation
- **Clock synchronisation**
  - `cpu_clock` passes through `SYNC_STAGES` flops, giving `sclk`.
  - `dbg_clock` = `sclk`.
  - A rise is `sclk` high while its previous-cycle value was low.
- **FSM states**
  - IDLE: on a rise, go to CAPTURE.
  - CAPTURE: one cycle. Latch snapshot, increment `step_cnt`, go to NOTIFY.
  - NOTIFY: `dbg_we`=1 for `HOLD_CYCLES` cycles (counted by `hold_cnt`). When it expires, go to CAPTURE if `pending`=1 (and clear `pending`), otherwise go to IDLE.
  - A rise seen in any state other than IDLE sets `pending`. There is only one pending slot; further rises while `pending`=1 are dropped.
- **Snapshot map** (words latched in CAPTURE):
  - word 0: {`cpu_ir`,`cpu_pc`}
  - word 1: {`cpu_b`,`cpu_a`}
  - word 2: {`cpu_md`,`cpu_ma`}
  - word 3: {12'h000,`cpu_flags`}
  - words 4–13: 16'h0000
  - word 14: {8'h00,`prev_pc`}, where `prev_pc` is the pc from the previous capture
  - word 15: `step_cnt`
- **Step counter**: `step_cnt` is 16 bits and wraps from 16'hFFFF to 16'h0000. Word 15 shows the post-increment value, so the first capture after reset reads 1.
- **Read path**: `dbg_data` <= snapshot[`dbg_addr`] on every `clk`, registered. A read in the same cycle as CAPTURE returns the old word.
- **`cpu_reset`=1** (level):
  - FSM forced to IDLE; `pending`, `hold_cnt` and `dbg_we` cleared.
  - `step_cnt`=0, `prev_valid`=0, `dbg_end_sq`=0.
  - Snapshot contents are retained.
  - Rises seen during `cpu_reset` are ignored.
- **`reset` (async)**: all registers cleared, including the snapshot, and FSM to IDLE. Asserting it mid-NOTIFY drops `dbg_we` immediately.

## Timing
- Reset values: `dbg_data`=0, `dbg_we`=0, `dbg_clock`=0, `dbg_end_sq`=0.
- `cpu_clock` rise to `dbg_clock` rise: `SYNC_STAGES` to `SYNC_STAGES`+1 cycles.
- Rise detected in cycle N (IDLE): CAPTURE in N+1; snapshot and `dbg_we` valid from N+2; `dbg_we` high for cycles N+2 .. N+1+`HOLD_CYCLES`.
- `dbg_addr` to `dbg_data`: 1 cycle.
- Back-to-back rises: `dbg_we` goes low for exactly 1 cycle (the CAPTURE cycle) between strobes.
- Core state inputs must be stable from the `cpu_clock` edge until CAPTURE. This holds because the CDECV step period is far longer than `SYNC_STAGES`+2 `clk` cycles.

## Configuration
- `DBG_END_SQ_EN` defined:
  - In CAPTURE, if `prev_valid`=1 and `cpu_pc`==`prev_pc`, set `dbg_end_sq`. This is a jump-to-self halt.
  - The flag rises in the same cycle as `dbg_we` and stays set until `reset` or `cpu_reset`.
- Not defined: `dbg_end_sq` is constant 0 and the comparison logic is absent. `prev_pc` and word 14 still operate.

## Test plan
- Reset, then read all 16 addresses: `dbg_data`=16'h0000 each; `dbg_we`=`dbg_end_sq`=`dbg_clock`=0.
- One `cpu_clock` pulse with pc=8'h12, ir=8'hA5, a=8'h01, b=8'h02, flags=4'hC:
  - `dbg_we` high exactly 4 cycles.
  - word0=16'hA512, word1=16'h0201, word3=16'h000C, word15=16'h0001.
- Second `cpu_clock` rise while the first NOTIFY is active: one-cycle gap in `dbg_we`, then a second 4-cycle strobe; word15=2.
- `DBG_END_SQ_EN` set; two steps with pc=8'h30:
  - `dbg_end_sq`=1 after the second CAPTURE; word14=16'h0030.
  - Pulse `cpu_reset`: `dbg_end_sq`=0, word15 unchanged, next step reads word15=1.
- Preload `step_cnt`=16'hFFFF (via 65535 steps or force), then one step: word15=16'h0000.
- Assert `reset` mid-NOTIFY: `dbg_we` drops asynchronously and all 16 words read 0.
